// File: rtl/player_bullet_pkg.sv
// Shared constants, slot state type and rectangle-overlap helper for the player bullet logic.
package player_bullet_pkg;

    localparam int NUM_SLOTS_DEF = 4;
    localparam int BULLET_W_DEF  = 4;
    localparam int BULLET_H_DEF  = 12;
    localparam int SPEED_DEF     = 4;
    localparam int COOLDOWN_DEF  = 16;
    localparam int MUZZLE_DX_DEF = 23;
    localparam int PLANE_W_DEF   = 50;
    localparam int PLANE_H_DEF   = 40;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [11:0] BULLET_RGB = 12'hFF0;

    typedef enum logic {
        FREE = 1'b0,
        FLY  = 1'b1
    } slotState_e;

    // Extended to 11 bits so that x + w near the right edge cannot wrap around.
    function automatic logic rect_overlap(
        input logic [9:0] ax, input logic [9:0] ay, input logic [9:0] aw, input logic [9:0] ah,
        input logic [9:0] bx, input logic [9:0] by, input logic [9:0] bw, input logic [9:0] bh);
        logic [10:0] axl, ayl, awl, ahl, bxl, byl, bwl, bhl;
        axl = {1'b0, ax};
        ayl = {1'b0, ay};
        awl = {1'b0, aw};
        ahl = {1'b0, ah};
        bxl = {1'b0, bx};
        byl = {1'b0, by};
        bwl = {1'b0, bw};
        bhl = {1'b0, bh};
        return (axl < bxl + bwl) && (axl + awl > bxl) &&
               (ayl < byl + bhl) && (ayl + ahl > byl);
    endfunction

endpackage

// File: rtl/player_bullet_slot.sv
// One player bullet: position registers, FREE/FLY state, upward motion, enemy overlap and pixel hit.
module player_bullet_slot
    import player_bullet_pkg::*;
#(
    parameter int BULLET_W = BULLET_W_DEF,
    parameter int BULLET_H = BULLET_H_DEF,
    parameter int SPEED    = SPEED_DEF,
    parameter int PLANE_W  = PLANE_W_DEF,
    parameter int PLANE_H  = PLANE_H_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       launch_i,
    input  logic [9:0] launchX_i,
    input  logic [9:0] launchY_i,
    input  logic       moveTick_i,
    input  logic [9:0] epX_i,
    input  logic [9:0] epY_i,
    input  logic       enemyExist_i,
    input  logic [9:0] pixX_i,
    input  logic [9:0] pixY_i,
    output logic       active_o,
    output logic       activeNext_o,
    output logic       overlap_o,
    output logic       pixelHit_o
);

    localparam logic [9:0] BW_V    = 10'(BULLET_W);
    localparam logic [9:0] BH_V    = 10'(BULLET_H);
    localparam logic [9:0] SPEED_V = 10'(SPEED);
    localparam logic [9:0] PW_V    = 10'(PLANE_W);
    localparam logic [9:0] PH_V    = 10'(PLANE_H);

    slotState_e state_q, state_d;
    logic [9:0] bx_q, bx_d, by_q, by_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FREE;
            bx_q    <= '0;
            by_q    <= '0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
        end
    end

    // A hit wins over motion; a FREE slot only ever sees a launch, so it never moves on its launch cycle.
    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        case (state_q)
            FREE: begin
                if (launch_i) begin
                    state_d = FLY;
                    bx_d    = launchX_i;
                    by_d    = launchY_i;
                end
            end
            FLY: begin
                if (overlap_o) begin
                    state_d = FREE;
                end else if (moveTick_i) begin
                    if (by_q < SPEED_V) begin
                        state_d = FREE;
                    end else begin
                        by_d = by_q - SPEED_V;
                    end
                end
            end
            default: state_d = FREE;
        endcase
    end

    // The pixel test is an overlap against a 1x1 rectangle at the scan position.
    always_comb begin
        active_o     = (state_q == FLY);
        activeNext_o = (state_d == FLY);
        overlap_o    = active_o && enemyExist_i &&
                       rect_overlap(bx_q, by_q, BW_V, BH_V, epX_i, epY_i, PW_V, PH_V);
        pixelHit_o   = active_o &&
                       rect_overlap(bx_q, by_q, BW_V, BH_V, pixX_i, pixY_i, 10'd1, 10'd1);
    end

endmodule

// File: rtl/player_bullet_ctrl.sv
// Player bullet pool: fire edge detect, cooldown, lowest-free slot allocation, hit pulse, count and pixel OR.
module player_bullet_ctrl
    import player_bullet_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    parameter int BULLET_W  = BULLET_W_DEF,
    parameter int BULLET_H  = BULLET_H_DEF,
    parameter int SPEED     = SPEED_DEF,
    parameter int COOLDOWN  = COOLDOWN_DEF,
    parameter int MUZZLE_DX = MUZZLE_DX_DEF,
    parameter int PLANE_W   = PLANE_W_DEF,
    parameter int PLANE_H   = PLANE_H_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_tick,
    input  logic        fire,
    input  logic [9:0]  pp_x,
    input  logic [9:0]  pp_y,
    input  logic [9:0]  ep_x,
    input  logic [9:0]  ep_y,
    input  logic        enemyplane_exist,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    output logic        player_bullet_en,
    output logic [11:0] player_bullet_rgb,
    output logic [2:0]  bullet_count,
    output logic        enemy_hit
);

    localparam int         CD_W      = $clog2(COOLDOWN + 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
    localparam logic [9:0] BH_V      = 10'(BULLET_H);
    localparam logic [9:0] MUZZLE_V  = 10'(MUZZLE_DX);

    logic            fire_q;
    logic [CD_W-1:0] cooldown_q, cooldown_d;
    logic            enemyHit_q, enemyHit_d;
    logic [2:0]      count_q, count_d;

    logic [NUM_SLOTS-1:0] slotActive, slotActiveNext, slotOverlap, slotPixel, launchVec;
    logic                 fireRise, canLaunch, found;
    logic [9:0]           launchX, launchY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_q     <= 1'b0;
            cooldown_q <= '0;
            enemyHit_q <= 1'b0;
            count_q    <= '0;
        end else begin
            fire_q     <= fire;
            cooldown_q <= cooldown_d;
            enemyHit_q <= enemyHit_d;
            count_q    <= count_d;
        end
    end

    // Availability is judged on registered state, so a slot freed this cycle is not handed out until the next.
    always_comb begin
        fireRise  = fire & ~fire_q;
        canLaunch = fireRise && (cooldown_q == '0) && !(&slotActive) && (pp_y >= BH_V);
        launchX   = pp_x + MUZZLE_V;
        launchY   = pp_y - BH_V;
        launchVec = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!slotActive[i] && !found) begin
                launchVec[i] = canLaunch;
                found        = 1'b1;
            end
        end
    end

    always_comb begin
        cooldown_d = cooldown_q;
        if (canLaunch) begin
            cooldown_d = CD_LOAD;
        end else if (move_tick && (cooldown_q != '0)) begin
            cooldown_d = cooldown_q - CD_ONE;
        end
        enemyHit_d = |slotOverlap;
        count_d    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_d = count_d + 3'(slotActiveNext[i]);
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : gSlot
        player_bullet_slot #(
            .BULLET_W (BULLET_W),
            .BULLET_H (BULLET_H),
            .SPEED    (SPEED),
            .PLANE_W  (PLANE_W),
            .PLANE_H  (PLANE_H)
        ) uSlot (
            .clk          (clk),
            .rst          (rst),
            .launch_i     (launchVec[g]),
            .launchX_i    (launchX),
            .launchY_i    (launchY),
            .moveTick_i   (move_tick),
            .epX_i        (ep_x),
            .epY_i        (ep_y),
            .enemyExist_i (enemyplane_exist),
            .pixX_i       (x),
            .pixY_i       (y),
            .active_o     (slotActive[g]),
            .activeNext_o (slotActiveNext[g]),
            .overlap_o    (slotOverlap[g]),
            .pixelHit_o   (slotPixel[g])
        );
    end

    always_comb begin
        player_bullet_en  = |slotPixel;
        player_bullet_rgb = player_bullet_en ? BULLET_RGB : 12'h000;
        bullet_count      = count_q;
        enemy_hit         = enemyHit_q;
    end

endmodule

// File: tb/tb_player_bullet_ctrl.sv
// Bench for player_bullet_ctrl: directed scenarios plus randomized play against a list-of-bullets model.
module tb_player_bullet_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        move_tick = 1'b0;
    logic        fire = 1'b0;
    logic [9:0]  pp_x = '0, pp_y = '0, ep_x = '0, ep_y = '0, x = '0, y = '0;
    logic        enemyplane_exist = 1'b0;
    logic        player_bullet_en;
    logic [11:0] player_bullet_rgb;
    logic [2:0]  bullet_count;
    logic        enemy_hit;

    int testsRun = 0;
    int testsFailed = 0;

    // Model: each bullet is just an (active, x, y) record; the world advances once per clock edge.
    bit mActive[4] = '{0, 0, 0, 0};
    int mBx[4]     = '{0, 0, 0, 0};
    int mBy[4]     = '{0, 0, 0, 0};
    int mCooldown  = 0;
    bit mFireQ     = 0;
    bit mHit       = 0;
    int mCount     = 0;

    player_bullet_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .move_tick         (move_tick),
        .fire              (fire),
        .pp_x              (pp_x),
        .pp_y              (pp_y),
        .ep_x              (ep_x),
        .ep_y              (ep_y),
        .enemyplane_exist  (enemyplane_exist),
        .x                 (x),
        .y                 (y),
        .player_bullet_en  (player_bullet_en),
        .player_bullet_rgb (player_bullet_rgb),
        .bullet_count      (bullet_count),
        .enemy_hit         (enemy_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin : modelStep
        bit hitSlot[4];
        bit anyHit, rise, launch;
        int freeSlot;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mActive[i] = 0;
                mBx[i] = 0;
                mBy[i] = 0;
            end
            mCooldown = 0;
            mFireQ = 0;
            mHit = 0;
            mCount = 0;
        end else begin
            anyHit = 0;
            for (int i = 0; i < 4; i++) begin
                hitSlot[i] = mActive[i] && enemyplane_exist &&
                             (mBx[i] < int'(ep_x) + 50) && (mBx[i] + 4 > int'(ep_x)) &&
                             (mBy[i] < int'(ep_y) + 40) && (mBy[i] + 12 > int'(ep_y));
                if (hitSlot[i]) anyHit = 1;
            end
            freeSlot = -1;
            for (int i = 3; i >= 0; i--) begin
                if (!mActive[i]) freeSlot = i;
            end
            rise   = fire && !mFireQ;
            launch = rise && (mCooldown == 0) && (freeSlot >= 0) && (int'(pp_y) >= 12);
            for (int i = 0; i < 4; i++) begin
                if (mActive[i]) begin
                    if (hitSlot[i]) mActive[i] = 0;
                    else if (move_tick) begin
                        if (mBy[i] < 4) mActive[i] = 0;
                        else mBy[i] = mBy[i] - 4;
                    end
                end
            end
            if (launch) begin
                mActive[freeSlot] = 1;
                mBx[freeSlot] = (int'(pp_x) + 23) % 1024;
                mBy[freeSlot] = int'(pp_y) - 12;
                mCooldown = 16;
            end else if (move_tick && mCooldown > 0) begin
                mCooldown = mCooldown - 1;
            end
            mFireQ = fire;
            mHit = anyHit;
            mCount = 0;
            for (int i = 0; i < 4; i++) mCount = mCount + int'(mActive[i]);
        end
    end

    function automatic bit modelEn(int px, int py);
        for (int i = 0; i < 4; i++) begin
            if (mActive[i] && mBx[i] <= px && px < mBx[i] + 4 && mBy[i] <= py && py < mBy[i] + 12)
                return 1;
        end
        return 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("model_count", int'(bullet_count), mCount);
        checkOutput("model_enemy_hit", int'(enemy_hit), int'(mHit));
        checkOutput("model_pixel_en", int'(player_bullet_en), int'(modelEn(int'(x), int'(y))));
        checkOutput("model_pixel_rgb", int'(player_bullet_rgb),
                    modelEn(int'(x), int'(y)) ? 32'hFF0 : 32'h000);
    end

    task automatic applyStimulus(input bit tick, input bit fireLevel, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            move_tick = tick;
            fire = fireLevel;
            @(posedge clk);
            #1;
            move_tick = 1'b0;
        end
    endtask

    task automatic tickOnce();
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 2);
        rst = 1'b0;
    endtask

    task automatic checkPixel(input string name, input int px, input int py, input bit expEn);
        @(posedge clk);
        #1;
        x = 10'(px);
        y = 10'(py);
        #1;
        checkOutput({name, "_en"}, int'(player_bullet_en), int'(expEn));
        checkOutput({name, "_rgb"}, int'(player_bullet_rgb), expEn ? 32'hFF0 : 32'h000);
    endtask

    task automatic launchAt(input int px, input int py);
        pp_x = 10'(px);
        pp_y = 10'(py);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainSeq
        int s;
        doReset();
        checkOutput("reset_count", int'(bullet_count), 0);
        checkOutput("reset_enemy_hit", int'(enemy_hit), 0);
        checkOutput("reset_pixel_en", int'(player_bullet_en), 0);

        // Single launch, exact muzzle position, pixel edges, one move.
        launchAt(300, 400);
        checkOutput("t1_count", int'(bullet_count), 1);
        checkPixel("t1_origin", 323, 388, 1'b1);
        checkPixel("t1_right_edge", 327, 388, 1'b0);
        checkPixel("t1_far_corner", 326, 399, 1'b1);
        checkPixel("t1_below", 323, 400, 1'b0);
        tickOnce();
        checkPixel("t1_moved", 323, 384, 1'b1);
        checkPixel("t1_moved_above", 323, 383, 1'b0);

        // Held fire, cooldown rejection, then acceptance after 16 ticks.
        doReset();
        pp_x = 10'd300;
        pp_y = 10'd400;
        applyStimulus(1'b0, 1'b1, 100);
        checkOutput("t2_held_fire", int'(bullet_count), 1);
        applyStimulus(1'b0, 1'b0, 1);
        for (int i = 0; i < 5; i++) tickOnce();
        launchAt(300, 400);
        checkOutput("t2_cooldown_reject", int'(bullet_count), 1);
        for (int i = 0; i < 11; i++) tickOnce();
        launchAt(300, 400);
        checkOutput("t2_second_launch", int'(bullet_count), 2);

        // Fill the pool, reject a fifth, free the third bullet by a hit and reuse it.
        for (int i = 0; i < 16; i++) tickOnce();
        launchAt(300, 400);
        checkOutput("t3_third", int'(bullet_count), 3);
        for (int i = 0; i < 16; i++) tickOnce();
        launchAt(300, 400);
        checkOutput("t3_fourth", int'(bullet_count), 4);
        for (int i = 0; i < 16; i++) tickOnce();
        launchAt(300, 400);
        checkOutput("t3_fifth_reject", int'(bullet_count), 4);
        ep_x = 10'd310;
        ep_y = 10'd250;
        enemyplane_exist = 1'b1;
        applyStimulus(1'b0, 1'b0, 1);
        enemyplane_exist = 1'b0;
        checkOutput("t3_hit_pulse", int'(enemy_hit), 1);
        checkOutput("t3_after_hit_count", int'(bullet_count), 3);
        checkPixel("t3_freed_gone", 323, 262, 1'b0);
        launchAt(300, 400);
        checkOutput("t3_reuse_count", int'(bullet_count), 4);
        checkOutput("t3_pulse_ended", int'(enemy_hit), 0);
        checkPixel("t3_reused_pixel", 323, 388, 1'b1);

        // Top exit and launch height boundary.
        doReset();
        launchAt(100, 15);
        checkOutput("t4_low_launch", int'(bullet_count), 1);
        tickOnce();
        checkOutput("t4_exit_count", int'(bullet_count), 0);
        checkOutput("t4_exit_no_hit", int'(enemy_hit), 0);
        doReset();
        launchAt(100, 11);
        checkOutput("t4_too_high_reject", int'(bullet_count), 0);

        // Enemy hit after exactly 13 moves, then the same flight with the enemy absent.
        doReset();
        ep_x = 10'd310;
        ep_y = 10'd300;
        enemyplane_exist = 1'b1;
        launchAt(300, 400);
        for (int i = 0; i < 12; i++) tickOnce();
        checkOutput("t5_no_hit_yet", int'(enemy_hit), 0);
        checkOutput("t5_still_flying", int'(bullet_count), 1);
        tickOnce();
        checkOutput("t5_hit", int'(enemy_hit), 1);
        checkOutput("t5_freed", int'(bullet_count), 0);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("t5_single_pulse", int'(enemy_hit), 0);
        doReset();
        enemyplane_exist = 1'b0;
        launchAt(300, 400);
        for (int i = 0; i < 13; i++) tickOnce();
        checkOutput("t5_absent_no_hit", int'(enemy_hit), 0);
        checkOutput("t5_absent_flying", int'(bullet_count), 1);
        for (int i = 0; i < 90; i++) tickOnce();
        checkOutput("t5_absent_exit", int'(bullet_count), 0);

        // Asynchronous reset mid-flight.
        doReset();
        launchAt(300, 400);
        checkPixel("t6_before_rst", 323, 388, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t6_async_count", int'(bullet_count), 0);
        checkOutput("t6_async_en", int'(player_bullet_en), 0);
        checkOutput("t6_async_rgb", int'(player_bullet_rgb), 0);
        applyStimulus(1'b0, 1'b0, 1);
        rst = 1'b0;

        // Randomized play, with enemy and pixel positions steered toward live bullets.
        for (int c = 0; c < 4000; c++) begin
            pp_x = 10'($urandom_range(600));
            pp_y = 10'($urandom_range(479));
            enemyplane_exist = ($urandom_range(3) != 0);
            s = int'($urandom_range(3));
            if (mActive[s] && $urandom_range(1) == 1) begin
                ep_x = 10'(mBx[s] - int'($urandom_range(55)));
                ep_y = 10'(mBy[s] - int'($urandom_range(45)));
            end else begin
                ep_x = 10'($urandom_range(589));
                ep_y = 10'($urandom_range(439));
            end
            if (mActive[s]) begin
                x = 10'(mBx[s] + int'($urandom_range(5)) - 1);
                y = 10'(mBy[s] + int'($urandom_range(13)) - 1);
            end else begin
                x = 10'($urandom_range(639));
                y = 10'($urandom_range(479));
            end
            if ($urandom_range(499) == 0) begin
                rst = 1'b1;
                applyStimulus(1'b0, 1'b0, 1);
                rst = 1'b0;
            end else begin
                applyStimulus($urandom_range(3) == 0, $urandom_range(2) != 0, 1);
            end
        end

        applyStimulus(1'b0, 1'b0, 2);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
